frame_sync: RTL

FRAME_SYNC -- requirements
Module: frame_sync

---
 rtl/frame_sync.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/frame_sync.sv
// rtl/frame_sync.sv - sync-word hunter and payload byte assembler for a hard-decided bit stream
module frame_sync #(
    parameter logic [15:0] SYNC_WORD     = 16'hEB90,
    parameter int          PAYLOAD_BYTES = 8,
    parameter int          MAX_ERR       = 1
) (
    input  logic        clk_16M384,
    input  logic        rst_16M384,
    input  logic        bit_in,
    input  logic        bit_vld,
    output logic [7:0]  byte_out,
    output logic        byte_vld,
    output logic        frame_start,
    output logic        frame_end,
    output logic        locked,
    output logic        inverted,
    output logic [15:0] frame_cnt
);

    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] PAYLOAD = 1'b1;

    localparam logic [4:0] MAX_ERR_W = 5'(MAX_ERR);
    localparam logic [7:0] LAST_IDX  = 8'(PAYLOAD_BYTES - 1);
    localparam logic [4:0] FILL_FULL = 5'd16;

    logic [0:0]  state_q,     state_d;
    logic [15:0] sr_q,        sr_d;
    logic [4:0]  fill_q,      fill_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  byte_cnt_q,  byte_cnt_d;
    logic [7:0]  acc_q,       acc_d;
    logic [7:0]  byte_out_q,  byte_out_d;
    logic        byte_vld_q,  byte_vld_d;
    logic        fstart_q,    fstart_d;
    logic        fend_q,      fend_d;
    logic        inverted_q,  inverted_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic [15:0] next_sr;
    logic [4:0]  fill_inc;
    logic [4:0]  dist_norm;
    logic [4:0]  dist_inv;
    logic        match_norm;
    logic        match_inv;

    // Number of set bits in a 16-bit word; result width holds 0..16 without truncation
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

    // Candidate marker window and its distance to both marker polarities
    always_comb begin
        next_sr    = {sr_q[14:0], bit_in};
        fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 5'd1;
        dist_norm  = popcount16(next_sr ^ SYNC_WORD);
        dist_inv   = popcount16(next_sr ^ ~SYNC_WORD);
        match_norm = (fill_inc == FILL_FULL) && (dist_norm <= MAX_ERR_W);
        match_inv  = (fill_inc == FILL_FULL) && (dist_inv <= MAX_ERR_W);
    end

    // Next-state logic: marker hunt, then fixed-length payload assembly
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        acc_d       = acc_q;
        byte_out_d  = byte_out_q;
        byte_vld_d  = 1'b0;
        fstart_d    = 1'b0;
        fend_d      = 1'b0;
        inverted_d  = inverted_q;
        frame_cnt_d = frame_cnt_q;

        if (bit_vld) begin
            case (state_q)
                HUNT: begin
                    sr_d   = next_sr;
                    fill_d = fill_inc;
                    // Normal polarity wins when both polarities are within tolerance
                    if (match_norm || match_inv) begin
                        state_d     = PAYLOAD;
                        inverted_d  = !match_norm;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        bit_cnt_d   = 3'd0;
                        byte_cnt_d  = 8'd0;
                    end
                end
                PAYLOAD: begin
                    acc_d     = {acc_q[6:0], bit_in ^ inverted_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_out_d = acc_d;
                        byte_vld_d = 1'b1;
                        fstart_d   = (byte_cnt_q == 8'd0);
                        fend_d     = (byte_cnt_q == LAST_IDX);
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        // Last byte: rearm the hunter with an empty window so the
                        // following marker may start on the very next bit
                        if (byte_cnt_q == LAST_IDX) begin
                            state_d    = HUNT;
                            sr_d       = 16'd0;
                            fill_d     = 5'd0;
                            byte_cnt_d = 8'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            state_q     <= HUNT;
            sr_q        <= 16'd0;
            fill_q      <= 5'd0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 8'd0;
            acc_q       <= 8'd0;
            byte_out_q  <= 8'd0;
            byte_vld_q  <= 1'b0;
            fstart_q    <= 1'b0;
            fend_q      <= 1'b0;
            inverted_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            acc_q       <= acc_d;
            byte_out_q  <= byte_out_d;
            byte_vld_q  <= byte_vld_d;
            fstart_q    <= fstart_d;
            fend_q      <= fend_d;
            inverted_q  <= inverted_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign byte_out    = byte_out_q;
    assign byte_vld    = byte_vld_q;
    assign frame_start = fstart_q;
    assign frame_end   = fend_q;
    assign locked      = (state_q == PAYLOAD);
    assign inverted    = inverted_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
